// File: rtl/snn_pkg.sv
// Shared types and helpers for the parametrised SNN core.
// Latency: none, declarations and a combinational function only.
// Backpressure: not applicable.
package snn_pkg;

  typedef enum logic [1:0] {IDLE, ENC, ACC, FIRE} state_t;

  // Signed add that saturates the result to a w-bit two's complement range.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int w);
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s  = a + b;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/snn_lif_unit.sv
// One LIF output neuron: weighted-sum accumulator, leak/saturate/floor, fire, window spike counter.
// Latency: spike and latched count registered on the fire cycle.
// Backpressure: none; strobes from the core sequencer are acted on unconditionally.
module snn_lif_unit
  import snn_pkg::*;
#(
  parameter int WW         = 16,
  parameter int VW         = 24,
  parameter int CW         = 10,
  parameter int V_TH       = 4096,
  parameter int V_RESET    = 0,
  parameter int V_MIN      = -16384,
  parameter int LEAK_SHIFT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 add_en,
  input  logic signed [WW-1:0] w,
  input  logic                 fire,
  input  logic                 win_end,
  output logic                 spike,
  output logic [CW-1:0]        spike_cnt
);

  logic signed [VW-1:0] sum;
  logic signed [VW-1:0] v;
  logic signed [VW-1:0] v_leak;
  logic signed [VW-1:0] v_new;
  logic signed [63:0]   v_wide;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        cnt_inc;
  logic                 fire_now;

  always_comb begin
    v_leak = v - (v >>> LEAK_SHIFT);
    v_wide = sat_add(64'(v_leak), 64'(sum), VW);
    if (v_wide < 64'(V_MIN)) v_wide = 64'(V_MIN);
    v_new    = v_wide[VW-1:0];
    fire_now = (v_wide >= 64'(V_TH));
    cnt_inc  = (fire_now && (cnt != '1)) ? cnt + 1'b1 : cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum       <= '0;
      v         <= '0;
      cnt       <= '0;
      spike     <= 1'b0;
      spike_cnt <= '0;
    end else begin
      if (clr) sum <= '0;
      else if (add_en) sum <= sum + VW'(w);
      if (fire) begin
        spike <= fire_now;
        v     <= fire_now ? VW'(V_RESET) : v_new;
        // Latch the post-increment count so the closing step's spike is kept.
        if (win_end) begin
          spike_cnt <= cnt_inc;
          cnt       <= '0;
        end else begin
          cnt <= cnt_inc;
        end
      end
    end
  end

endmodule

// File: rtl/snn_core_param.sv
// SNN core: rate encoders, runtime-writable weight array, sequential accumulate into N_OUT LIF neurons.
// Latency: spike_valid N_IN+2 edges after the edge that samples en.
// Backpressure: en only accepted in IDLE (else overrun sticks); weight writes only while w_ready.
module snn_core_param
  import snn_pkg::*;
#(
  parameter int N_IN       = 4,
  parameter int N_OUT      = 2,
  parameter int SW         = 12,
  parameter int WW         = 16,
  parameter int VW         = 24,
  parameter int V_TH       = 4096,
  parameter int V_RESET    = 0,
  parameter int V_MIN      = -16384,
  parameter int LEAK_SHIFT = 4,
  parameter int WIN_TICKS  = 8,
  parameter int CW         = 10,
  localparam int NW        = N_IN * N_OUT,
  localparam int AW        = (NW > 1) ? $clog2(NW) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [N_IN*SW-1:0]    sensor_in,
  input  logic [N_IN*SW-1:0]    enc_thr,
  input  logic                  w_we,
  input  logic [AW-1:0]         w_addr,
  input  logic signed [WW-1:0]  w_data,
  output logic                  w_ready,
  output logic                  busy,
  output logic [N_OUT-1:0]      out_spike,
  output logic                  spike_valid,
  output logic [N_OUT*CW-1:0]   spike_cnt,
  output logic                  cnt_valid,
  output logic                  overrun
);

  localparam int IW  = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int WXW = $clog2(WIN_TICKS + 1);

  state_t               state;
  logic [IW-1:0]        idx;
  logic [WXW-1:0]       win_idx;
  logic [N_IN-1:0]      pre_spk;
  logic [SW:0]          enc_acc [N_IN];
  logic [SW:0]          enc_sum [N_IN];
  logic [N_IN-1:0]      enc_hit;
  logic signed [WW-1:0] w_mem [NW];
  logic                 win_end;

  assign busy    = (state != IDLE);
  assign w_ready = (state == IDLE);
  assign win_end = (win_idx == WXW'(WIN_TICKS - 1));

  always_comb begin
    for (int i = 0; i < N_IN; i++) begin
      enc_sum[i] = enc_acc[i] + {1'b0, sensor_in[i*SW +: SW]};
      enc_hit[i] = (enc_sum[i] >= {1'b0, enc_thr[i*SW +: SW]});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      win_idx     <= '0;
      pre_spk     <= '0;
      spike_valid <= 1'b0;
      cnt_valid   <= 1'b0;
      overrun     <= 1'b0;
      for (int i = 0; i < N_IN; i++) enc_acc[i] <= '0;
      for (int k = 0; k < NW; k++) w_mem[k] <= '0;
    end else begin
      spike_valid <= 1'b0;
      cnt_valid   <= 1'b0;
      if (en && (state != IDLE)) overrun <= 1'b1;
      if (w_we && (state == IDLE)) w_mem[w_addr] <= w_data;
      case (state)
        IDLE: if (en) state <= ENC;
        ENC: begin
          for (int i = 0; i < N_IN; i++) begin
            pre_spk[i] <= enc_hit[i];
            enc_acc[i] <= enc_hit[i] ? enc_sum[i] - {1'b0, enc_thr[i*SW +: SW]} : enc_sum[i];
          end
          idx   <= '0;
          state <= ACC;
        end
        ACC: begin
          idx <= idx + 1'b1;
          if (idx == IW'(N_IN - 1)) state <= FIRE;
        end
        FIRE: begin
          spike_valid <= 1'b1;
          if (win_end) begin
            cnt_valid <= 1'b1;
            win_idx   <= '0;
          end else begin
            win_idx <= win_idx + 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // One input channel per ACC cycle feeds every neuron in parallel.
  for (genvar j = 0; j < N_OUT; j++) begin : g_lif
    logic [AW-1:0]        rd_addr;
    logic signed [WW-1:0] w_sel;
    assign rd_addr = AW'(int'(idx) * N_OUT + j);
    assign w_sel   = w_mem[rd_addr];

    snn_lif_unit #(
      .WW(WW), .VW(VW), .CW(CW), .V_TH(V_TH), .V_RESET(V_RESET),
      .V_MIN(V_MIN), .LEAK_SHIFT(LEAK_SHIFT)
    ) u_lif (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (state == ENC),
      .add_en    ((state == ACC) && pre_spk[idx]),
      .w         (w_sel),
      .fire      (state == FIRE),
      .win_end   (win_end),
      .spike     (out_spike[j]),
      .spike_cnt (spike_cnt[j*CW +: CW])
    );
  end

endmodule
